// File: rtl/sprite_mover_if.sv
// Bundles the gameLogic handshake and the VGA pixel bus of sprite_mover.
// The slave modport is the mover; the master modport is gameLogic plus the VGA adapter.
interface sprite_mover_if;
  logic [7:0] nextx;
  logic [6:0] nexty;
  logic       changeREGs;
  logic       enableGL;
  logic [7:0] currentX;
  logic [6:0] currentY;
  logic [7:0] vga_x;
  logic [6:0] vga_y;
  logic [2:0] vga_colour;
  logic       vga_plot;
  logic       busy;

  modport slave (
    input  nextx, nexty, changeREGs,
    output enableGL, currentX, currentY, vga_x, vga_y, vga_colour, vga_plot, busy
  );

  modport master (
    output nextx, nexty, changeREGs,
    input  enableGL, currentX, currentY, vga_x, vga_y, vga_colour, vga_plot, busy
  );
endinterface

// File: rtl/sprite_mover.sv
// Owns the sprite position, paces gameLogic once per frame and repaints a SIZE x SIZE box on the VGA adapter.
// Define MOVER_TRAIL_EN to compile out the erase pass so the sprite leaves a trail.
module sprite_mover #(
  parameter int         SIZE          = 4,
  parameter int         XMAX          = 160,
  parameter int         YMAX          = 120,
  parameter logic [7:0] X_INIT        = 8'd0,
  parameter logic [6:0] Y_INIT        = 7'd0,
  parameter int         FRAME_DELAY   = 10000,
  parameter logic [2:0] SPRITE_COLOUR = 3'b111,
  parameter logic [2:0] BG_COLOUR     = 3'b000
) (
  input  logic          clock,
  input  logic          resetn,
  sprite_mover_if.slave bus
);

  localparam logic [3:0]  OFS_LAST = 4'(SIZE - 1);
  localparam logic [19:0] DLY_LAST = 20'(FRAME_DELAY - 1);
  localparam logic [8:0]  X_LIM    = 9'(XMAX);
  localparam logic [7:0]  Y_LIM    = 8'(YMAX);

`ifdef MOVER_TRAIL_EN
  typedef enum logic [2:0] {S_DRAW, S_DELAY, S_REQ, S_WAIT} state_t;
`else
  typedef enum logic [2:0] {S_DRAW, S_DELAY, S_REQ, S_WAIT, S_ERASE} state_t;
`endif

  state_t      r_state;
  logic [7:0]  r_cur_x;
  logic [6:0]  r_cur_y;
  logic [7:0]  r_old_x;
  logic [6:0]  r_old_y;
  logic [3:0]  r_ox;
  logic [3:0]  r_oy;
  logic [19:0] r_dly;
  logic        r_en;
  logic        r_plot;
  logic [7:0]  r_vga_x;
  logic [6:0]  r_vga_y;
  logic [2:0]  r_colour;
  logic        r_busy;

  logic        w_erase;
  logic        w_sweep;
  logic        w_last;
  logic        w_moved;
  logic [7:0]  w_base_x;
  logic [6:0]  w_base_y;
  logic [8:0]  w_sum_x;
  logic [7:0]  w_sum_y;

`ifdef MOVER_TRAIL_EN
  assign w_erase = 1'b0;
`else
  assign w_erase = (r_state == S_ERASE);
`endif

  assign w_sweep  = (r_state == S_DRAW) || w_erase;
  assign w_last   = (r_ox == OFS_LAST) && (r_oy == OFS_LAST);
  assign w_moved  = (bus.nextx != r_cur_x) || (bus.nexty != r_cur_y);
  assign w_base_x = w_erase ? r_old_x : r_cur_x;
  assign w_base_y = w_erase ? r_old_y : r_cur_y;
  // Sums are one bit wider than the screen coordinates so edge clipping sees the carry.
  assign w_sum_x  = {1'b0, w_base_x} + {5'd0, r_ox};
  assign w_sum_y  = {1'b0, w_base_y} + {4'd0, r_oy};

  // Frame sequencer, sweep counters and registered pixel/handshake outputs.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_state  <= S_DRAW;
      r_cur_x  <= X_INIT;
      r_cur_y  <= Y_INIT;
      r_old_x  <= X_INIT;
      r_old_y  <= Y_INIT;
      r_ox     <= 4'd0;
      r_oy     <= 4'd0;
      r_dly    <= 20'd0;
      r_en     <= 1'b0;
      r_plot   <= 1'b0;
      r_vga_x  <= 8'd0;
      r_vga_y  <= 7'd0;
      r_colour <= 3'b000;
      r_busy   <= 1'b1;
    end else begin
      r_plot <= 1'b0;
      r_en   <= 1'b0;
      if (w_sweep) begin
        r_vga_x  <= w_sum_x[7:0];
        r_vga_y  <= w_sum_y[6:0];
        r_colour <= w_erase ? BG_COLOUR : SPRITE_COLOUR;
        r_plot   <= (w_sum_x < X_LIM) && (w_sum_y < Y_LIM);
        if (r_ox == OFS_LAST) begin
          r_ox <= 4'd0;
          r_oy <= (r_oy == OFS_LAST) ? 4'd0 : r_oy + 4'd1;
        end else begin
          r_ox <= r_ox + 4'd1;
        end
      end
      case (r_state)
        S_DRAW: begin
          if (w_last) begin
            r_state <= S_DELAY;
            r_busy  <= 1'b0;
          end
        end
`ifndef MOVER_TRAIL_EN
        S_ERASE: begin
          if (w_last) begin
            r_state <= S_DRAW;
          end
        end
`endif
        S_DELAY: begin
          if (r_dly == DLY_LAST) begin
            r_dly   <= 20'd0;
            r_en    <= 1'b1;
            r_state <= S_REQ;
          end else begin
            r_dly <= r_dly + 20'd1;
          end
        end
        S_REQ: begin
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          if (bus.changeREGs) begin
            r_old_x <= r_cur_x;
            r_old_y <= r_cur_y;
            r_cur_x <= bus.nextx;
            r_cur_y <= bus.nexty;
            // A stationary sprite needs no repaint, only the next frame delay.
            if (w_moved) begin
              r_busy <= 1'b1;
`ifdef MOVER_TRAIL_EN
              r_state <= S_DRAW;
`else
              r_state <= S_ERASE;
`endif
            end else begin
              r_state <= S_DELAY;
            end
          end
        end
        default: begin
          r_state <= S_DELAY;
          r_busy  <= 1'b0;
          r_dly   <= 20'd0;
        end
      endcase
    end
  end

  assign bus.enableGL   = r_en;
  assign bus.currentX   = r_cur_x;
  assign bus.currentY   = r_cur_y;
  assign bus.vga_x      = r_vga_x;
  assign bus.vga_y      = r_vga_y;
  assign bus.vga_colour = r_colour;
  assign bus.vga_plot   = r_plot;
  assign bus.busy       = r_busy;

endmodule

// File: tb/tb_sprite_mover.sv
// Self-checking bench for sprite_mover: a cycle timeline model of plots, enableGL and position
// is compared every cycle, with directed moves, clipping, ignored strobes, random traffic and reset.
module tb_sprite_mover;
  localparam int         SIZE = 4;
  localparam int         N    = SIZE * SIZE;
  localparam int         F    = 20;
  localparam logic [7:0] XI   = 8'd10;
  localparam logic [6:0] YI   = 7'd20;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sprite_mover_if ifc();

  sprite_mover #(.SIZE(SIZE), .X_INIT(XI), .Y_INIT(YI), .FRAME_DELAY(F)) dut (
    .clock (clk),
    .resetn(rst_n),
    .bus   (ifc)
  );

  typedef struct packed {
    logic       plot;
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] col;
  } pix_t;

  pix_t       exp_pix[int];
  bit         exp_busy[int];
  pix_t       held;
  int         cyc, en_due, fg_cnt, bg_cnt;
  logic [7:0] cur_x;
  logic [6:0] cur_y;
  int         checks = 0;
  int         errors = 0;
  logic       s_plot, s_en;
  logic [7:0] s_x, s_cx;
  logic [6:0] s_y, s_cy;
  logic [2:0] s_col;

  function automatic void chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d cycle=%0d", name, act, exp, cyc);
    end
  endfunction

  // One SIZE x SIZE sweep whose counters start in cycle s; each pixel is visible one cycle later.
  function automatic void sched(input int s, input int bx, input int by, input logic [2:0] col);
    for (int k = 0; k < N; k++) begin
      int   px, py;
      pix_t p;
      px = bx + (k % SIZE);
      py = by + (k / SIZE);
      p.plot = (px < 160) && (py < 120);
      p.x    = px[7:0];
      p.y    = py[6:0];
      p.col  = col;
      exp_pix[s + 1 + k] = p;
      exp_busy[s + k]    = 1'b1;
    end
  endfunction

  function automatic void model_init();
    exp_pix.delete();
    exp_busy.delete();
    cyc    = 0;
    held   = '0;
    cur_x  = XI;
    cur_y  = YI;
    sched(0, int'(XI), int'(YI), 3'b111);
    en_due = N + F;
  endfunction

  function automatic void accept(input logic [7:0] nx, input logic [6:0] ny);
    if (nx == cur_x && ny == cur_y) begin
      en_due = cyc + 1 + F;
    end else begin
`ifdef MOVER_TRAIL_EN
      sched(cyc + 1, int'(nx), int'(ny), 3'b111);
      en_due = cyc + 1 + N + F;
`else
      sched(cyc + 1, int'(cur_x), int'(cur_y), 3'b000);
      sched(cyc + 1 + N, int'(nx), int'(ny), 3'b111);
      en_due = cyc + 1 + 2 * N + F;
`endif
    end
    cur_x = nx;
    cur_y = ny;
  endfunction

  function automatic void check_cycle();
    pix_t e;
    if (exp_pix.exists(cyc)) begin
      e = exp_pix[cyc];
      exp_pix.delete(cyc);
      held = e;
    end else begin
      e = held;
      e.plot = 1'b0;
    end
    s_plot = ifc.vga_plot; s_x = ifc.vga_x; s_y = ifc.vga_y; s_col = ifc.vga_colour;
    s_en = ifc.enableGL; s_cx = ifc.currentX; s_cy = ifc.currentY;
    chk("vga_plot", int'(s_plot), int'(e.plot));
    chk("vga_x", int'(s_x), int'(e.x));
    chk("vga_y", int'(s_y), int'(e.y));
    chk("vga_colour", int'(s_col), int'(e.col));
    chk("enableGL", int'(s_en), int'(cyc == en_due));
    chk("busy", int'(ifc.busy), int'(exp_busy.exists(cyc)));
    if (exp_busy.exists(cyc)) exp_busy.delete(cyc);
    chk("currentX", int'(s_cx), int'(cur_x));
    chk("currentY", int'(s_cy), int'(cur_y));
    if (s_plot) begin
      if (s_col == 3'b111) fg_cnt++;
      else bg_cnt++;
    end
  endfunction

  task automatic tick(input bit s, input logic [7:0] nx, input logic [6:0] ny);
    @(negedge clk);
    check_cycle();
    ifc.changeREGs = s;
    ifc.nextx      = nx;
    ifc.nexty      = ny;
    if (s && cyc > en_due) accept(nx, ny);
    @(posedge clk);
    cyc++;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (cyc <= en_due && n < 1000) begin
      tick(1'b0, 8'd0, 7'd0);
      n++;
    end
    chk("wait_idle_bound", int'(n < 1000), 1);
  endtask

  // Asynchronous reset applied between clock edges, then released to restart the model.
  task automatic do_reset();
    #2;
    rst_n = 1'b0;
    ifc.changeREGs = 1'b0;
    #1;
    chk("rst_plot", int'(ifc.vga_plot), 0);
    chk("rst_en", int'(ifc.enableGL), 0);
    chk("rst_cx", int'(ifc.currentX), int'(XI));
    chk("rst_cy", int'(ifc.currentY), int'(YI));
    chk("rst_vx", int'(ifc.vga_x), 0);
    chk("rst_vy", int'(ifc.vga_y), 0);
    chk("rst_col", int'(ifc.vga_colour), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_init();
    @(posedge clk);
    cyc = 1;
  endtask

  initial begin
    int         trail_bg;
    logic [7:0] nx;
    logic [6:0] ny;
    bit         s;
`ifdef MOVER_TRAIL_EN
    trail_bg = 0;
`else
    trail_bg = 16;
`endif
    ifc.changeREGs = 1'b0;
    ifc.nextx      = 8'd0;
    ifc.nexty      = 7'd0;
    fg_cnt = 0;
    bg_cnt = 0;
    #12;
    do_reset();
    chk("t1_model_en_due", en_due, 36);

    // T1: first pixel, last pixel and enableGL FRAME_DELAY cycles after it.
    tick(1'b0, 8'd0, 7'd0);
    chk("t1_first_plot", int'(s_plot), 1);
    chk("t1_first_x", int'(s_x), 10);
    chk("t1_first_y", int'(s_y), 20);
    chk("t1_first_col", int'(s_col), 7);
    repeat (15) tick(1'b0, 8'd0, 7'd0);
    chk("t1_last_x", int'(s_x), 13);
    chk("t1_last_y", int'(s_y), 23);
    repeat (20) tick(1'b0, 8'd0, 7'd0);
    chk("t1_en_at_36", int'(s_en), 1);
    tick(1'b0, 8'd0, 7'd0);
    chk("t1_en_one_cycle", int'(s_en), 0);
    chk("t1_fg_count", fg_cnt, 16);
    wait_idle();

    // T2: move right by one.
    fg_cnt = 0; bg_cnt = 0;
    tick(1'b1, 8'd11, 7'd20);
    tick(1'b0, 8'd0, 7'd0);
    chk("t2_cx_next_cycle", int'(s_cx), 11);
    wait_idle();
    chk("t2_fg_count", fg_cnt, 16);
    chk("t2_bg_count", bg_cnt, trail_bg);

    // T3: stationary, no repaint.
    fg_cnt = 0; bg_cnt = 0;
    s = 1'b1;
    tick(s, 8'd11, 7'd20);
    chk("t3_model_en_gap", en_due - (cyc - 1), F + 1);
    wait_idle();
    chk("t3_plots", fg_cnt + bg_cnt, 0);

    // T4: bottom-right clip.
    fg_cnt = 0; bg_cnt = 0;
    tick(1'b1, 8'd158, 7'd118);
    wait_idle();
    chk("t4_fg_count", fg_cnt, 4);
    chk("t4_bg_count", bg_cnt, trail_bg);

    // T5a: strobe during DELAY is ignored.
    tick(1'b1, 8'd158, 7'd118);
    tick(1'b1, 8'd50, 7'd50);
    tick(1'b0, 8'd0, 7'd0);
    chk("t5_ignore_cx", int'(s_cx), 158);
    chk("t5_ignore_cy", int'(s_cy), 118);
    wait_idle();

    // Random traffic: stops, steps, edge positions and stray strobes.
    for (int i = 0; i < 2500; i++) begin
      s = (cyc > en_due) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 40) == 0);
      case ($urandom_range(0, 3))
        0: begin nx = cur_x; ny = cur_y; end
        1: begin nx = 8'($urandom_range(0, 159)); ny = 7'($urandom_range(0, 119)); end
        2: begin nx = 8'($urandom_range(155, 159)); ny = 7'($urandom_range(115, 119)); end
        default: begin
          nx = (cur_x == 8'd159) ? 8'd0 : cur_x + 8'd1;
          ny = cur_y;
        end
      endcase
      tick(s, nx, ny);
    end
    wait_idle();

    // T5b: reset in the middle of a DRAW sweep.
    nx = (cur_x == 8'd40) ? 8'd41 : 8'd40;
    tick(1'b1, nx, 7'd30);
    while (cyc < en_due - F - 8) tick(1'b0, 8'd0, 7'd0);
    chk("t5_mid_draw_busy", int'(ifc.busy), 1);
    do_reset();
    fg_cnt = 0;
    wait_idle();
    chk("t5_redraw_fg", fg_cnt, 16);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
